board_uart_tx: RTL
==================

# board_uart_tx

Serializes a snapshot of the game state over a UART link so a host PC can mirror the board. The state block writes the two concatenated 121-cell planes, the game status and the NNUE state score; this block reads them. On a `start` pulse it latches all of that, packs it into a fixed 36-byte frame and shifts the frame out 8N1 on `tx`. It runs in the 25 MHz display/game clock domain, beside the VGA display.

## Interface
- `CLKS_PER_BIT`, default 217, clock cycles per UART bit (25 MHz / 115200). Legal values are 2 or more.
- `clk` input 1: system clock (25 MHz domain).
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to send a frame. Honoured only when `busy` = 0.
- `board` input [0:241]: `board[0:120]` is the player-0 plane and `board[121:241]` is the player-1 plane. 1 means a stone is present.
- `game_status` input 2: current game status.
- `score` input 16: state score.
- `tx` output 1: UART line. Idle level is high.
- `busy` output 1: high while a frame is in flight.
- `done` output 1: one-cycle pulse when the frame completes.

## Operation
- **Reset.** `tx` = 1, `busy` = 0, `done` = 0. The sequencer goes to IDLE and the byte index and bit counters clear.
- **Snapshot.** When `start` = 1 and `busy` = 0, latch `board`, `game_status` and `score` in that same cycle. Input changes after that have no effect on the frame.
- **Start while busy.** A `start` with `busy` = 1 is ignored. It is not queued.
- **Cell code for cell i (0..120).** `{board[121+i], board[i]}`:
  - 00 = empty, 01 = player 0, 10 = player 1.
  - 11 is sent as-is; the block does not check it.
- **Frame byte order (36 bytes):**
  - byte 0 = 0xA5 header.
  - bytes 1..31 = packed cells. Byte 1+k carries cell 4k in bits [1:0], cell 4k+1 in [3:2], cell 4k+2 in [5:4], cell 4k+3 in [7:6]. Cells 121..123 are padded with 00.
  - byte 32 = `{6'b0, game_status}`.
  - byte 33 = `score[15:8]`.
  - byte 34 = `score[7:0]`.
  - byte 35 = XOR of bytes 1..34.
- **Checksum.** Accumulate it as bytes are loaded, or compute it from the snapshot. Either way, byte 35 must equal the XOR above.
- **Byte-level FSM:** IDLE -> START_BIT -> DATA (8 bits, LSB first) -> STOP_BIT.
  - After STOP_BIT, go to START_BIT of the next byte, or to IDLE after byte 35.
  - Bit lengths: start = 0, data = bit value, stop = 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - There are no idle gaps between bytes.
- **Reset mid-frame.** The frame is abandoned. `tx` = 1 on the next cycle and `done` is not pulsed.

## Timing
- `start` accepted at cycle T:
  - `busy` = 1 and `tx` = 0 (header start bit) from T+1.
  - Each byte occupies 10×`CLKS_PER_BIT` cycles.
  - The last stop bit ends at cycle T+360×`CLKS_PER_BIT`.
- Completion, at cycle T+360×`CLKS_PER_BIT`+1:
  - `done` = 1 for exactly one cycle.
  - `busy` = 0 and `tx` = 1.
  - A `start` in that same cycle is accepted. The next frame's start bit appears one cycle later.
- Outputs `tx`, `busy` and `done` are all registered, with no combinational path from inputs.

## Test plan
- **Reset.** Hold `rst` 3 cycles, mid-frame and at idle -> `tx` = 1, `busy` = 0, `done` = 0 on the cycle after reset. No `done` pulse follows.
- **Empty board.** `game_status` = 2'b01, `score` = 0x1234, `CLKS_PER_BIT` = 4.
  - Decoded bytes: A5, 31×00, 01, 12, 34, 27.
  - `done` arrives exactly 1441 cycles after the `start` cycle.
- **Cell packing.** Stone of player 0 at cell 0, player 1 at cell 5, player 1 at cell 120.
  - byte1 = 0x01, byte2 = 0x08, byte31 = 0x02.
  - Checksum equals the XOR of bytes 1..34, recomputed by the bench.
- **Snapshot isolation.** Flip every `board` bit and change `score` to 0xFFFF during byte 10 -> the frame matches the values at the `start` cycle.
- **Start handling.**
  - Pulse `start` during byte 20 -> ignored, and exactly 36 bytes are sent.
  - Pulse `start` on the `done` cycle -> a second frame begins with no gap beyond one idle cycle.
- **Bit timing.** With `CLKS_PER_BIT` = 217, measure the widths of the start, data and stop bits -> each is exactly 217 cycles, LSB first.

Source files
------------

// File: rtl/board_uart_tx.sv
// board_uart_tx: snapshots the two 121-cell board planes, the game status and
// the state score on a start pulse, packs them into a fixed 36-byte frame
// (header, packed cells, status, score, XOR checksum) and shifts the frame
// out 8N1 on tx with no gaps between bytes.
//
// Handshake: start is a single-cycle request that is accepted only in a cycle
// where busy = 0; a start seen while busy = 1 is dropped, not queued. done
// pulses for one cycle after the last stop bit, and in that same cycle
// busy = 0, so a new start may be accepted there.
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:241] board,
    input  logic [1:0]   game_status,
    input  logic [15:0]  score,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]     LAST_BYTE = 6'd35;
    localparam logic [7:0]     HEADER    = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

    state_t         state;
    logic [CW-1:0]  clk_cnt;
    logic [2:0]     bit_idx;
    logic [5:0]     byte_idx;
    logic [7:0]     shift_q;
    logic [7:0]     chk_q;

    // Snapshot taken in the start-accept cycle
    logic [0:241]   board_q;
    logic [1:0]     status_q;
    logic [15:0]    score_q;

    // Packed cell stream: cell c occupies bits [2c+1:2c]; cells 121..127 stay 0
    logic [255:0]   cells;
    logic [5:0]     next_idx;
    logic [7:0]     next_byte;

    // Pack the snapshot planes into 2-bit cell codes {player1, player0}
    always_comb begin
        cells = '0;
        for (int c = 0; c < 121; c++) begin
            cells[2*c +: 2] = {board_q[121+c], board_q[c]};
        end
    end

    // Select the byte that follows the one currently on the line
    always_comb begin
        next_idx  = byte_idx + 6'd1;
        next_byte = 8'h00;
        if (next_idx == 6'd0) begin
            next_byte = HEADER;
        end else if (next_idx <= 6'd31) begin
            // byte 1+k carries cells 4k..4k+3, i.e. cells[8k +: 8] with k = byte_idx
            next_byte = cells[{byte_idx[4:0], 3'b000} +: 8];
        end else if (next_idx == 6'd32) begin
            next_byte = {6'b0, status_q};
        end else if (next_idx == 6'd33) begin
            next_byte = score_q[15:8];
        end else if (next_idx == 6'd34) begin
            next_byte = score_q[7:0];
        end else begin
            next_byte = chk_q;
        end
    end

    // Frame sequencer: IDLE -> START_BIT -> DATA x8 -> STOP_BIT, per byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift_q  <= '0;
            chk_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        board_q  <= board;
                        status_q <= game_status;
                        score_q  <= score;
                        state    <= START_BIT;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        shift_q  <= HEADER;
                        chk_q    <= '0;
                    end
                end

                START_BIT: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift_q[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_BIT;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx      <= shift_q[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            byte_idx <= next_idx;
                            shift_q  <= next_byte;
                            // checksum covers bytes 1..34 only
                            if (next_idx != LAST_BYTE) begin
                                chk_q <= chk_q ^ next_byte;
                            end
                            state <= START_BIT;
                            tx    <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
